// File: rtl/nv_fifo_rws_128x128_ctrl.sv
// Valid/ready FIFO controller for an external registered-read-address two-port RAM.
// Optional macro NV_FIFO_RWS_BYPASS_EN: pushes into an empty FIFO skip the RAM and land in the skid.
module nv_fifo_rws_128x128_ctrl #(
    parameter int WIDTH = 128,
    parameter int AW    = 7
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic             ram_we,
    output logic [AW-1:0]    ram_wa,
    output logic [WIDTH-1:0] ram_di,
    output logic             ram_re,
    output logic [AW-1:0]    ram_ra,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [7:0]       fifo_cnt
);

    localparam logic [7:0] DEPTH = 8'(1 << AW);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [7:0]       ram_used_q, ram_used_d;
    logic [7:0]       fifo_cnt_q, fifo_cnt_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       skid_cnt_q, skid_cnt_d;
    logic [WIDTH-1:0] skid0_q, skid0_d;
    logic [WIDTH-1:0] skid1_q, skid1_d;

    logic             push;
    logic             pop;
    logic             byp;
    logic             ram_push;
    logic             rel;
    logic             issue;
    logic             cap;
    logic [1:0]       skid_after_pop;
    logic [WIDTH-1:0] cap_data;

    assign wr_prdy        = (ram_used_q < DEPTH);
    assign rd_pvld        = (skid_cnt_q != 2'd0);
    assign push           = wr_pvld && wr_prdy;
    assign pop            = rd_pvld && rd_prdy;
    assign skid_after_pop = skid_cnt_q - {1'b0, pop};

`ifdef NV_FIFO_RWS_BYPASS_EN
    assign byp = push && (ram_used_q == 8'd0) && !inflight_q && (skid_after_pop < 2'd2);
`else
    assign byp = 1'b0;
`endif

    assign ram_push = push && !byp;
    // A slot is freed only once its read data has been captured, so the write port cannot clobber it.
    assign rel      = inflight_q;
    assign issue    = (ram_used_q > {7'd0, inflight_q}) &&
                      (({1'b0, skid_cnt_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
    assign cap      = inflight_q || byp;
    assign cap_data = inflight_q ? ram_dout : wr_pd;

    assign ram_we   = ram_push;
    assign ram_wa   = wr_ptr_q;
    assign ram_di   = wr_pd;
    assign ram_re   = issue;
    assign ram_ra   = rd_ptr_q;
    assign rd_pd    = skid0_q;
    assign fifo_cnt = fifo_cnt_q;

    always_comb begin
        skid0_d = skid0_q;
        skid1_d = skid1_q;
        if (pop) begin
            skid0_d = skid1_q;
        end
        if (cap) begin
            if (skid_after_pop == 2'd0) begin
                skid0_d = cap_data;
            end else begin
                skid1_d = cap_data;
            end
        end
        skid_cnt_d = skid_after_pop + {1'b0, cap};
        wr_ptr_d   = wr_ptr_q + AW'(ram_push);
        rd_ptr_d   = rd_ptr_q + AW'(issue);
        ram_used_d = ram_used_q + 8'(ram_push) - 8'(rel);
        inflight_d = issue;
        fifo_cnt_d = ram_used_d + 8'(skid_cnt_d);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_used_q <= '0;
            fifo_cnt_q <= '0;
            inflight_q <= 1'b0;
            skid_cnt_q <= '0;
            skid0_q    <= '0;
            skid1_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_used_q <= ram_used_d;
            fifo_cnt_q <= fifo_cnt_d;
            inflight_q <= inflight_d;
            skid_cnt_q <= skid_cnt_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
        end
    end

endmodule

// File: tb/tb_nv_fifo_rws_128x128_ctrl.sv
// Directed bench for nv_fifo_rws_128x128_ctrl with a behavioural 128x128 registered-address RAM.
module tb_nv_fifo_rws_128x128_ctrl;

    logic         clk;
    logic         rst_n;
    logic         wr_pvld;
    logic         wr_prdy;
    logic [127:0] wr_pd;
    logic         rd_pvld;
    logic         rd_prdy;
    logic [127:0] rd_pd;
    logic         ram_we;
    logic [6:0]   ram_wa;
    logic [127:0] ram_di;
    logic         ram_re;
    logic [6:0]   ram_ra;
    logic [127:0] ram_dout;
    logic [7:0]   fifo_cnt;

    nv_fifo_rws_128x128_ctrl #(.WIDTH(128), .AW(7)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rst_n),
        .wr_pvld        (wr_pvld),
        .wr_prdy        (wr_prdy),
        .wr_pd          (wr_pd),
        .rd_pvld        (rd_pvld),
        .rd_prdy        (rd_prdy),
        .rd_pd          (rd_pd),
        .ram_we         (ram_we),
        .ram_wa         (ram_wa),
        .ram_di         (ram_di),
        .ram_re         (ram_re),
        .ram_ra         (ram_ra),
        .ram_dout       (ram_dout),
        .fifo_cnt       (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: write on the edge, read address latched on ram_re, dout combinational from it.
    logic [127:0] mem [0:127];
    logic [6:0]   ra_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
    end
    assign ram_dout = mem[ra_q];

    int errors = 0;
    int checks = 0;
    int acc_total = 0;
    int pop_total = 0;
    logic [127:0] sb [$];
    bit   busy [0:127];
    bit   rel_pend = 1'b0;
    logic [6:0] rel_ra = '0;

    task automatic chk(input string tag, input logic [127:0] obs_v, input logic [127:0] exp_v);
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs_v, exp_v);
        end
    endtask

    task automatic chkb(input string tag, input logic obs_v, input logic exp_v);
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs_v, exp_v);
        end
    endtask

    task automatic chki(input string tag, input int obs_v, input int exp_v);
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs_v, exp_v);
        end
    endtask

    function automatic logic [127:0] word(input int unsigned n);
        return {4{n}};
    endfunction

    task automatic clear_model();
        sb.delete();
        foreach (busy[i]) busy[i] = 1'b0;
        rel_pend = 1'b0;
    endtask

    // Mid-cycle observation: slot-reuse monitor plus in-order scoreboard.
    task automatic obs();
        @(negedge clk);
        if (ram_we) chkb("slot_free", busy[ram_wa], 1'b0);
        if (rel_pend) busy[rel_ra] = 1'b0;
        rel_pend = ram_re;
        rel_ra   = ram_ra;
        if (ram_we) busy[ram_wa] = 1'b1;
        if (rd_pvld && rd_prdy) begin
            pop_total++;
            chkb("pop_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) chk("pop_data", rd_pd, sb.pop_front());
        end
        if (wr_pvld && wr_prdy) begin
            sb.push_back(wr_pd);
            acc_total++;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    int cyc;
    int abase;
    int pbase;

    initial begin
        rst_n   = 1'b0;
        wr_pvld = 1'b0;
        wr_pd   = '0;
        rd_prdy = 1'b0;
        clear_model();

        // Reset state
        @(negedge clk);
        chkb("rst_pvld", rd_pvld, 1'b0);
        chkb("rst_prdy", wr_prdy, 1'b1);
        chki("rst_cnt", int'(fifo_cnt), 0);
        chkb("rst_we", ram_we, 1'b0);
        chkb("rst_re", ram_re, 1'b0);
        chk("rst_pd", rd_pd, 128'd0);
        adv();
        rst_n = 1'b1;
        adv();

        // Single push
        wr_pvld = 1'b1;
        wr_pd   = {16{8'hA5}};
        rd_prdy = 1'b1;
        obs();
`ifdef NV_FIFO_RWS_BYPASS_EN
        chkb("c0_we", ram_we, 1'b0);
`else
        chkb("c0_we", ram_we, 1'b1);
        chki("c0_wa", int'(ram_wa), 0);
        chk("c0_di", ram_di, {16{8'hA5}});
`endif
        adv();
        wr_pvld = 1'b0;
        obs();
        chki("c1_cnt", int'(fifo_cnt), 1);
`ifdef NV_FIFO_RWS_BYPASS_EN
        chkb("c1_pvld", rd_pvld, 1'b1);
        chk("c1_pd", rd_pd, {16{8'hA5}});
        adv();
`else
        chkb("c1_re", ram_re, 1'b1);
        chki("c1_ra", int'(ram_ra), 0);
        chkb("c1_pvld", rd_pvld, 1'b0);
        adv();
        obs();
        chkb("c2_re", ram_re, 1'b0);
        adv();
        obs();
        chkb("c3_pvld", rd_pvld, 1'b1);
        chk("c3_pd", rd_pd, {16{8'hA5}});
        adv();
`endif
        obs();
        chkb("single_done_pvld", rd_pvld, 1'b0);
        chki("single_done_cnt", int'(fifo_cnt), 0);
        adv();

        // Streaming 300 words, consumer always ready
        abase = acc_total;
        pbase = pop_total;
        wr_pvld = 1'b1;
        wr_pd   = word(0);
        rd_prdy = 1'b1;
        cyc = 0;
        while ((pop_total - pbase) < 300 && cyc < 1000) begin
            obs();
            cyc++;
            adv();
            wr_pvld = (acc_total - abase) < 300;
            wr_pd   = word(32'(acc_total - abase));
        end
        chki("stream_pops", pop_total - pbase, 300);
`ifdef NV_FIFO_RWS_BYPASS_EN
        chki("stream_cycles", cyc, 301);
`else
        chki("stream_cycles", cyc, 303);
`endif
        wr_pvld = 1'b0;
        obs();
        chki("stream_cnt", int'(fifo_cnt), 0);
        adv();

        // Fill with consumer stalled
        abase = acc_total;
        rd_prdy = 1'b0;
        wr_pvld = 1'b1;
        wr_pd   = word(32'h1000_0000);
        cyc = 0;
        while (cyc < 400) begin
            obs();
            cyc++;
            if (!wr_prdy) break;
            adv();
            wr_pd = word(32'h1000_0000 + 32'(acc_total - abase));
        end
        chki("full_acc", acc_total - abase, 130);
        chki("full_cnt", int'(fifo_cnt), 130);
        chkb("full_re", ram_re, 1'b0);
        chkb("full_pvld", rd_pvld, 1'b1);
        adv();
        rd_prdy = 1'b1;
        obs();
        chkb("full_push_refused", wr_prdy, 1'b0);
        adv();
        rd_prdy = 1'b0;
        obs();
        chkb("full_rel_prdy", wr_prdy, 1'b0);
        adv();
        obs();
        chkb("full_after_rel", wr_prdy, 1'b1);
        adv();
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        cyc = 0;
        while ((sb.size() != 0 || rd_pvld) && cyc < 400) begin
            obs();
            cyc++;
            adv();
        end
        chki("full_drain_left", sb.size(), 0);
        obs();
        chki("full_drain_cnt", int'(fifo_cnt), 0);
        adv();

        // Random traffic
        abase = acc_total;
        for (int i = 0; i < 400; i++) begin
            wr_pvld = 1'($urandom_range(0, 1));
            rd_prdy = 1'($urandom_range(0, 1));
            wr_pd   = word(32'h2000_0000 + 32'(acc_total - abase));
            obs();
            adv();
        end
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        cyc = 0;
        while ((sb.size() != 0 || rd_pvld) && cyc < 400) begin
            obs();
            cyc++;
            adv();
        end
        chki("rand_left", sb.size(), 0);
        obs();
        chki("rand_cnt", int'(fifo_cnt), 0);
        adv();

        // Reset while a read is in flight
        abase = acc_total;
        rd_prdy = 1'b0;
        wr_pvld = 1'b1;
        cyc = 0;
        while ((acc_total - abase) < 10 && cyc < 50) begin
            wr_pd = word(32'h3000_0000 + 32'(acc_total - abase));
            obs();
            cyc++;
            adv();
        end
        wr_pvld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obs();
            adv();
        end
        rd_prdy = 1'b1;
        obs();
        chki("pre_rst_cnt", int'(fifo_cnt), 10);
        chkb("pre_rst_re", ram_re, 1'b1);
        adv();
        rd_prdy = 1'b0;
        rst_n   = 1'b0;
        obs();
        chkb("mid_rst_pvld", rd_pvld, 1'b0);
        chki("mid_rst_cnt", int'(fifo_cnt), 0);
        chkb("mid_rst_prdy", wr_prdy, 1'b1);
        clear_model();
        adv();
        rst_n = 1'b1;
        adv();
        pbase   = pop_total;
        wr_pvld = 1'b1;
        wr_pd   = {4{32'h1234_5678}};
        rd_prdy = 1'b1;
        obs();
        adv();
        wr_pvld = 1'b0;
        cyc = 0;
        while ((pop_total - pbase) < 1 && cyc < 10) begin
            obs();
            cyc++;
            adv();
        end
        chki("post_rst_pops", pop_total - pbase, 1);
        obs();
        chki("post_rst_cnt", int'(fifo_cnt), 0);
        adv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
